matrix_load_sequencer: RTL and testbench
========================================

# matrix_load_sequencer

Controller that sequences the Cannon matrix multiplier in the VGA matrix display design. It accepts 2·N·N operand words over a valid/ready stream, packs them into the flat matrix A/B buses, pulses the multiplier's `read_ready`, and waits for `output_valid`. It then releases a one-cycle `frame_update` at the next vertical-blanking start, so the display only changes between frames.

## Interface
- `N`, 3: matrix dimension (square).
- `WIDTH`, 16: element width in bits.
- `TIMEOUT`, 1024: max cycles in WAIT_DONE; used only when `MATSEQ_TIMEOUT_EN` is defined.

- `clk`  in  1  system clock; the single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand word valid.
- `in_data`  in  WIDTH  operand word.
- `in_ready`  out  1  sequencer can accept a word (registered).
- `clear`  in  1  abort the current load, return to IDLE.
- `matrix_a`  out  N·N·WIDTH  packed A to multiplier `mat_a_in`.
- `matrix_b`  out  N·N·WIDTH  packed B to multiplier `mat_b_in`.
- `read_ready`  out  1  one-cycle start pulse to the multiplier.
- `compute_done`  in  1  multiplier `output_valid` (level).
- `vblank`  in  1  vertical blanking from `vertical_counter`.
- `frame_update`  out  1  one-cycle pulse: result committed for display.
- `busy`  out  1  high in every state except IDLE.
- `result_count`  out  8  number of committed results (wraps 255→0).
- `error`  out  1  sticky timeout flag.

## Operation
- States: IDLE, LOAD, START, WAIT_DONE, WAIT_VBLANK, COMMIT.
- Word index `w` runs 0..2·N·N−1. Words 0..N·N−1 go to A and the rest go to B, in row-major order. Element e = r·N+c occupies bits [e·WIDTH +: WIDTH] of its bus.
- A transfer occurs when `in_valid && in_ready`. Only transferred words are written. Elements not yet rewritten keep their previous values.
- IDLE: `in_ready`=1.
  - The first transfer writes A[0], sets w=1 and moves to LOAD.
- LOAD: each transfer writes element w and increments w.
  - The transfer at w=2·N·N−1 moves to START and resets w to 0.
- START: `read_ready`=1 for exactly this cycle, then go to WAIT_DONE.
- WAIT_DONE: wait for a rising edge of `compute_done`, detected against a one-cycle delayed copy. A level that is already high on entry does not count. On the edge, go to WAIT_VBLANK.
- WAIT_VBLANK: wait for a rising edge of `vblank`, then go to COMMIT. If both edges arrive in the same cycle, the `vblank` edge is not consumed; the sequencer waits for the next one.
- COMMIT: `frame_update`=1 for one cycle, `result_count` increments, then go to IDLE.
- `clear` takes effect in IDLE and LOAD only: w=0, state=IDLE, bus contents unchanged. `clear` is ignored in all other states. If `clear` and a transfer occur in the same cycle, `clear` wins and the word is dropped.
- `matrix_a` and `matrix_b` are held stable from START until the next transfer.

## Timing
- Reset values: state IDLE, w=0, `in_ready`=0, `read_ready`=0, `frame_update`=0, `busy`=0, `result_count`=0, `error`=0, `matrix_a`=0, `matrix_b`=0, edge-detect registers=0.
- `in_ready` becomes 1 in the first cycle after `reset` deasserts.
- `in_ready` drops to 0 in the cycle after the last word is accepted, so at most 2·N·N words are accepted per operation.
- `read_ready` is asserted in the cycle after the last transfer.
- `in_ready` rises again in the cycle after `frame_update`.
- Minimum throughput is one word per cycle with `in_valid` held high.
- Asserting `reset` in any state aborts the operation on the next edge and restores the reset values.

## Configuration
- `MATSEQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT_DONE and is cleared on entry to that state.
  - After `TIMEOUT` cycles without a `compute_done` edge, the sequencer sets `error`=1 and returns to IDLE with no `frame_update`.
  - `error` clears only on `reset`.
- `MATSEQ_TIMEOUT_EN` undefined:
  - WAIT_DONE waits indefinitely.
  - `error` is tied to 0 and no counter logic is present.

## Test plan
- Reset, then stream 18 words 1..18 with `in_valid` held high:
  - `matrix_a` element 0 = 1, element 8 = 9; `matrix_b` element 0 = 10, element 8 = 18.
  - `read_ready` pulses once, one cycle after word 18.
  - `in_ready`=0 from that cycle.
- Raise `compute_done` 20 cycles after START, then raise `vblank` 100 cycles later:
  - exactly one `frame_update` pulse, 2 cycles after the `vblank` edge;
  - `result_count`=1; `in_ready`=1 the following cycle.
- Hold `compute_done` high from before START:
  - no transition out of WAIT_DONE until it falls and rises again.
- Assert `clear` after 7 words, then send 18 new words 100..117:
  - `matrix_a` element 0 = 100; only one `read_ready` pulse;
  - word 7 of the aborted load is never seen on the bus.
- With `MATSEQ_TIMEOUT_EN`, `TIMEOUT`=16, and `compute_done` tied low:
  - `error`=1 at WAIT_DONE entry + 16 cycles; state returns to IDLE; no `frame_update`.
- Assert `reset` during WAIT_VBLANK:
  - all outputs return to their reset values the next cycle;
  - the `vblank` edge that follows produces no `frame_update`.

Source files
------------

// File: rtl/matrix_load_sequencer_if.sv
// Operand stream, multiplier handshake and display-commit signals of the
// matrix load sequencer, bundled for connection between the sequencer
// (slave side) and its driver/consumer (master side).
interface matrix_load_sequencer_if #(
    parameter int N     = 3,
    parameter int WIDTH = 16
) ();
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic                   clear;
    logic [N*N*WIDTH-1:0]   matrix_a;
    logic [N*N*WIDTH-1:0]   matrix_b;
    logic                   read_ready;
    logic                   compute_done;
    logic                   vblank;
    logic                   frame_update;
    logic                   busy;
    logic [7:0]             result_count;
    logic                   error;

    modport slave (
        input  in_valid, in_data, clear, compute_done, vblank,
        output in_ready, matrix_a, matrix_b, read_ready, frame_update,
               busy, result_count, error
    );

    modport master (
        output in_valid, in_data, clear, compute_done, vblank,
        input  in_ready, matrix_a, matrix_b, read_ready, frame_update,
               busy, result_count, error
    );
endinterface

// File: rtl/matrix_load_sequencer.sv
// Sequencer for the Cannon matrix multiplier: collects 2*N*N operand words,
// packs them into the A/B buses, starts the multiplier, waits for its result
// and commits it to the display at the next vertical-blanking start.
// Optional feature macro: MATSEQ_TIMEOUT_EN (WAIT_DONE timeout + sticky error).
module matrix_load_sequencer #(
    parameter int N       = 3,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    matrix_load_sequencer_if.slave  bus
);
    localparam int NN    = N * N;
    localparam int WORDS = 2 * NN;
    localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BUSW  = NN * WIDTH;

    if (N < 1 || WIDTH < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("matrix_load_sequencer: N, WIDTH and TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        WAIT_VBLANK,
        COMMIT
    } state_t;

    state_t          state;
    logic [WW-1:0]   w;
    logic            in_ready_r;
    logic            read_ready_r;
    logic            frame_update_r;
    logic [7:0]      result_count_r;
    logic [BUSW-1:0] mat_a;
    logic [BUSW-1:0] mat_b;
    logic            cd_q, cd_qq;
    logic            vb_q, vb_qq;
    logic            cd_rise, vb_rise;
    logic            xfer, last_word, load_phase;

    assign xfer       = bus.in_valid && in_ready_r;
    assign last_word  = (w == WW'(WORDS - 1));
    assign load_phase = (state == IDLE) || (state == LOAD);
    assign cd_rise    = cd_q && !cd_qq;
    assign vb_rise    = vb_q && !vb_qq;

`ifdef MATSEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          error_r;
    assign bus.error = error_r;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.in_ready     = in_ready_r;
    assign bus.read_ready   = read_ready_r;
    assign bus.frame_update = frame_update_r;
    assign bus.result_count = result_count_r;
    assign bus.busy         = (state != IDLE);
    assign bus.matrix_a     = mat_a;
    assign bus.matrix_b     = mat_b;

    // Sample compute_done/vblank and keep a delayed copy for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            cd_q  <= 1'b0;
            cd_qq <= 1'b0;
            vb_q  <= 1'b0;
            vb_qq <= 1'b0;
        end else begin
            cd_q  <= bus.compute_done;
            cd_qq <= cd_q;
            vb_q  <= bus.vblank;
            vb_qq <= vb_q;
        end
    end

    // Write each accepted operand word into its row-major slot of A or B
    always_ff @(posedge clk) begin
        if (reset) begin
            mat_a <= '0;
            mat_b <= '0;
        end else if (xfer && load_phase && !bus.clear) begin
            if (int'(w) < NN)
                mat_a[int'(w)*WIDTH +: WIDTH] <= bus.in_data;
            else
                mat_b[(int'(w) - NN)*WIDTH +: WIDTH] <= bus.in_data;
        end
    end

    // Control FSM with registered handshake/pulse outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            w              <= '0;
            in_ready_r     <= 1'b0;
            read_ready_r   <= 1'b0;
            frame_update_r <= 1'b0;
            result_count_r <= '0;
`ifdef MATSEQ_TIMEOUT_EN
            tcnt           <= '0;
            error_r        <= 1'b0;
`endif
        end else begin
            read_ready_r   <= 1'b0;
            frame_update_r <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (bus.clear) begin
                        w <= '0;
                    end else if (xfer) begin
                        w     <= WW'(1);
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.clear) begin
                        w     <= '0;
                        state <= IDLE;
                    end else if (xfer) begin
                        if (last_word) begin
                            w            <= '0;
                            state        <= START;
                            in_ready_r   <= 1'b0;
                            read_ready_r <= 1'b1;
                        end else begin
                            w <= w + WW'(1);
                        end
                    end
                end
                START: begin
                    state <= WAIT_DONE;
`ifdef MATSEQ_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
                WAIT_DONE: begin
                    if (cd_rise) begin
                        state <= WAIT_VBLANK;
                    end
`ifdef MATSEQ_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT - 1)) begin
                        error_r    <= 1'b1;
                        state      <= IDLE;
                        in_ready_r <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
`endif
                end
                WAIT_VBLANK: begin
                    // A vblank edge coinciding with the compute_done edge was
                    // seen while still in WAIT_DONE and is therefore skipped.
                    if (vb_rise) begin
                        state          <= COMMIT;
                        frame_update_r <= 1'b1;
                        result_count_r <= result_count_r + 8'd1;
                    end
                end
                COMMIT: begin
                    state      <= IDLE;
                    in_ready_r <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Directed self-checking bench for matrix_load_sequencer (N=3, WIDTH=16,
// TIMEOUT=16). The timeout scenario runs only when MATSEQ_TIMEOUT_EN is defined.
module tb_matrix_load_sequencer;
    localparam int N     = 3;
    localparam int WIDTH = 16;
    localparam int NN    = N * N;
    localparam int BUSW  = NN * WIDTH;

    logic clk;
    logic reset;

    int total;
    int bad;
    int rr;
    int fu;
    logic [WIDTH-1:0] el;
    logic [BUSW-1:0]  exp_a;
    logic [BUSW-1:0]  exp_b;

    matrix_load_sequencer_if #(.N(N), .WIDTH(WIDTH)) bus ();

    matrix_load_sequencer #(.N(N), .WIDTH(WIDTH), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.clear = 1'b0;
        bus.compute_done = 1'b0;
        bus.vblank = 1'b0;
        tick(); tick(); tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0h exp=0", bus.in_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", bus.busy); end
        total++; if (bus.read_ready !== 1'b0) begin bad++; $display("FAIL reset_read_ready got=%0h exp=0", bus.read_ready); end
        total++; if (bus.frame_update !== 1'b0) begin bad++; $display("FAIL reset_frame_update got=%0h exp=0", bus.frame_update); end
        total++; if (bus.result_count !== 8'd0) begin bad++; $display("FAIL reset_result_count got=%0d exp=0", bus.result_count); end
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL reset_error got=%0h exp=0", bus.error); end
        total++; if (bus.matrix_a !== '0) begin bad++; $display("FAIL reset_matrix_a got=%0h exp=0", bus.matrix_a); end
        total++; if (bus.matrix_b !== '0) begin bad++; $display("FAIL reset_matrix_b got=%0h exp=0", bus.matrix_b); end
        reset = 1'b0;
        tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%0h exp=1", bus.in_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%0h exp=0", bus.busy); end
    endtask

    task automatic test_stream_load();
        rr = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2*NN; i++) begin
            bus.in_data = WIDTH'(1 + i);
            tick();
            if (bus.read_ready === 1'b1) rr++;
            if (i < 2*NN - 1) begin
                total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL load_in_ready_w%0d got=%0h exp=1", i, bus.in_ready); end
            end
        end
        total++; if (bus.read_ready !== 1'b1) begin bad++; $display("FAIL load_read_ready_after_last got=%0h exp=1", bus.read_ready); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL load_in_ready_after_last got=%0h exp=0", bus.in_ready); end
        bus.in_valid = 1'b0;
        tick();
        if (bus.read_ready === 1'b1) rr++;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL load_in_ready_wait got=%0h exp=0", bus.in_ready); end
        total++; if (rr !== 1) begin bad++; $display("FAIL load_read_ready_pulses got=%0d exp=1", rr); end
        el = bus.matrix_a[0 +: WIDTH];
        total++; if (el !== 16'd1) begin bad++; $display("FAIL load_a0 got=%0d exp=1", el); end
        el = bus.matrix_a[8*WIDTH +: WIDTH];
        total++; if (el !== 16'd9) begin bad++; $display("FAIL load_a8 got=%0d exp=9", el); end
        el = bus.matrix_b[0 +: WIDTH];
        total++; if (el !== 16'd10) begin bad++; $display("FAIL load_b0 got=%0d exp=10", el); end
        el = bus.matrix_b[8*WIDTH +: WIDTH];
        total++; if (el !== 16'd18) begin bad++; $display("FAIL load_b8 got=%0d exp=18", el); end
        for (int e = 0; e < NN; e++) begin
            exp_a[e*WIDTH +: WIDTH] = WIDTH'(1 + e);
            exp_b[e*WIDTH +: WIDTH] = WIDTH'(10 + e);
        end
        total++; if (bus.matrix_a !== exp_a) begin bad++; $display("FAIL load_matrix_a got=%0h exp=%0h", bus.matrix_a, exp_a); end
        total++; if (bus.matrix_b !== exp_b) begin bad++; $display("FAIL load_matrix_b got=%0h exp=%0h", bus.matrix_b, exp_b); end
    endtask

    task automatic test_compute_commit();
        fu = 0;
        for (int c = 0; c < 19; c++) begin
            tick();
            if (bus.frame_update === 1'b1) fu++;
        end
        bus.compute_done = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.frame_update === 1'b1) fu++;
        end
        total++; if (fu !== 0) begin bad++; $display("FAIL commit_early_frame_update got=%0d exp=0", fu); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL commit_busy_waiting got=%0h exp=1", bus.busy); end
        bus.vblank = 1'b1;
        tick();
        total++; if (bus.frame_update !== 1'b0) begin bad++; $display("FAIL commit_fu_plus1 got=%0h exp=0", bus.frame_update); end
        tick();
        total++; if (bus.frame_update !== 1'b1) begin bad++; $display("FAIL commit_fu_plus2 got=%0h exp=1", bus.frame_update); end
        total++; if (bus.result_count !== 8'd1) begin bad++; $display("FAIL commit_result_count got=%0d exp=1", bus.result_count); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL commit_in_ready_during got=%0h exp=0", bus.in_ready); end
        tick();
        total++; if (bus.frame_update !== 1'b0) begin bad++; $display("FAIL commit_fu_plus3 got=%0h exp=0", bus.frame_update); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL commit_in_ready_after got=%0h exp=1", bus.in_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL commit_busy_after got=%0h exp=0", bus.busy); end
        fu = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.frame_update === 1'b1) fu++;
        end
        total++; if (fu !== 0) begin bad++; $display("FAIL commit_extra_pulses got=%0d exp=0", fu); end
        bus.vblank = 1'b0;
    endtask

    task automatic test_held_compute_done();
        // compute_done is still high from the previous operation
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2*NN; i++) begin
            bus.in_data = WIDTH'(201 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        fu = 0;
        for (int c = 0; c < 32; c++) begin
            bus.vblank = ((c / 4) % 2) == 1;
            tick();
            if (bus.frame_update === 1'b1) fu++;
        end
        bus.vblank = 1'b0;
        total++; if (fu !== 0) begin bad++; $display("FAIL held_no_frame_update got=%0d exp=0", fu); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL held_busy got=%0h exp=1", bus.busy); end
        total++; if (bus.result_count !== 8'd1) begin bad++; $display("FAIL held_result_count got=%0d exp=1", bus.result_count); end
        bus.compute_done = 1'b0;
        tick(); tick();
        bus.compute_done = 1'b1;
        for (int c = 0; c < 7; c++) tick();
        bus.vblank = 1'b1;
        tick();
        tick();
        total++; if (bus.frame_update !== 1'b1) begin bad++; $display("FAIL held_fu_after_reedge got=%0h exp=1", bus.frame_update); end
        total++; if (bus.result_count !== 8'd2) begin bad++; $display("FAIL held_result_count2 got=%0d exp=2", bus.result_count); end
        tick();
        bus.vblank = 1'b0;
        bus.compute_done = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in_data = WIDTH'(50 + i);
            tick();
        end
        bus.in_data = 16'd57;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL clear_busy got=%0h exp=0", bus.busy); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL clear_in_ready got=%0h exp=1", bus.in_ready); end
        el = bus.matrix_a[7*WIDTH +: WIDTH];
        total++; if (el !== 16'd208) begin bad++; $display("FAIL clear_dropped_word got=%0d exp=208", el); end
        el = bus.matrix_a[6*WIDTH +: WIDTH];
        total++; if (el !== 16'd56) begin bad++; $display("FAIL clear_kept_word got=%0d exp=56", el); end
        tick();
        rr = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2*NN; i++) begin
            bus.in_data = WIDTH'(100 + i);
            tick();
            if (bus.read_ready === 1'b1) rr++;
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.read_ready === 1'b1) rr++;
        end
        total++; if (rr !== 1) begin bad++; $display("FAIL clear_read_ready_pulses got=%0d exp=1", rr); end
        el = bus.matrix_a[0 +: WIDTH];
        total++; if (el !== 16'd100) begin bad++; $display("FAIL clear_a0 got=%0d exp=100", el); end
        for (int e = 0; e < NN; e++) begin
            exp_a[e*WIDTH +: WIDTH] = WIDTH'(100 + e);
            exp_b[e*WIDTH +: WIDTH] = WIDTH'(109 + e);
        end
        total++; if (bus.matrix_a !== exp_a) begin bad++; $display("FAIL clear_matrix_a got=%0h exp=%0h", bus.matrix_a, exp_a); end
        total++; if (bus.matrix_b !== exp_b) begin bad++; $display("FAIL clear_matrix_b got=%0h exp=%0h", bus.matrix_b, exp_b); end
        // advance to WAIT_VBLANK for the reset scenario
        bus.compute_done = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL clear_busy_wait_vblank got=%0h exp=1", bus.busy); end
    endtask

    task automatic test_reset_in_wait_vblank();
        reset = 1'b1;
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%0h exp=0", bus.busy); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL midreset_in_ready got=%0h exp=0", bus.in_ready); end
        total++; if (bus.result_count !== 8'd0) begin bad++; $display("FAIL midreset_result_count got=%0d exp=0", bus.result_count); end
        total++; if (bus.matrix_a !== '0) begin bad++; $display("FAIL midreset_matrix_a got=%0h exp=0", bus.matrix_a); end
        total++; if (bus.matrix_b !== '0) begin bad++; $display("FAIL midreset_matrix_b got=%0h exp=0", bus.matrix_b); end
        total++; if (bus.frame_update !== 1'b0) begin bad++; $display("FAIL midreset_frame_update got=%0h exp=0", bus.frame_update); end
        total++; if (bus.read_ready !== 1'b0) begin bad++; $display("FAIL midreset_read_ready got=%0h exp=0", bus.read_ready); end
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL midreset_error got=%0h exp=0", bus.error); end
        reset = 1'b0;
        bus.vblank = 1'b1;
        fu = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.frame_update === 1'b1) fu++;
        end
        total++; if (fu !== 0) begin bad++; $display("FAIL midreset_vblank_frame_update got=%0d exp=0", fu); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midreset_in_ready_after got=%0h exp=1", bus.in_ready); end
        bus.vblank = 1'b0;
        bus.compute_done = 1'b0;
        tick(); tick();
    endtask

`ifdef MATSEQ_TIMEOUT_EN
    task automatic test_timeout();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2*NN; i++) begin
            bus.in_data = WIDTH'(300 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        total++; if (bus.read_ready !== 1'b1) begin bad++; $display("FAIL timeout_start got=%0h exp=1", bus.read_ready); end
        tick();
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL timeout_error_entry got=%0h exp=0", bus.error); end
        fu = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.frame_update === 1'b1) fu++;
        end
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL timeout_error_plus15 got=%0h exp=0", bus.error); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL timeout_busy_plus15 got=%0h exp=1", bus.busy); end
        tick();
        total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL timeout_error_plus16 got=%0h exp=1", bus.error); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL timeout_busy_plus16 got=%0h exp=0", bus.busy); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL timeout_in_ready got=%0h exp=1", bus.in_ready); end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.frame_update === 1'b1) fu++;
        end
        total++; if (fu !== 0) begin bad++; $display("FAIL timeout_frame_update got=%0d exp=0", fu); end
        total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL timeout_error_sticky got=%0h exp=1", bus.error); end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        exp_a = '0;
        exp_b = '0;
        test_reset();
        test_stream_load();
        test_compute_commit();
        test_held_compute_done();
        test_clear();
        test_reset_in_wait_vblank();
`ifdef MATSEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
